// File: rtl/data_mem_responder.sv
// Word-addressed 32-bit data memory that answers valid/ready requests after a fixed latency.
// Build option DMEM_RSP_BYTE_STROBE_EN enables per-byte write strobes (full-word writes otherwise).
module data_mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam bit         LAT1     = (LATENCY == 1);
  localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rd_ok_q, rd_ok_d;

  logic              accept;
  logic              enter_resp;
  logic              cur_we;
  logic [31:0]       cur_addr;
  logic [31:0]       cur_wdata;
  logic              cur_err;
  logic [ADDR_W-1:0] cur_idx;
  logic [3:0]        byte_en;
  logic              mem_we;

  logic [31:0] mem [DEPTH];
  logic [31:0] mem_rd_q;

  assign accept = req_valid & req_ready_q;

  // With LATENCY=1 the acceptance edge is also the edge entering RESP, so the
  // memory access must use the request ports directly instead of the latches.
  assign enter_resp = (state_q == IDLE) ? (accept & LAT1)
                                        : ((state_q == WAIT) && (cnt_q == 4'd0));

  assign cur_we    = (state_q == IDLE) ? req_we    : we_q;
  assign cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign cur_idx   = cur_addr[ADDR_W+1:2];
  assign cur_err   = (cur_addr[1:0] != 2'b00) | ((cur_addr >> (ADDR_W + 2)) != 32'd0);

`ifdef DMEM_RSP_BYTE_STROBE_EN
  logic [3:0] wstrb_q, wstrb_d;
  assign byte_en = (state_q == IDLE) ? req_wstrb : wstrb_q;
`else
  logic unused_wstrb;
  assign unused_wstrb = ^req_wstrb;
  assign byte_en      = 4'hF;
`endif

  // Reset gating keeps an aborted or reset-time request from touching storage.
  assign mem_we = enter_resp & cur_we & ~cur_err & ~rst;

  always_ff @(posedge clk) begin
    if (enter_resp) begin
      mem_rd_q <= mem[cur_idx];
    end
    if (mem_we && byte_en[0]) mem[cur_idx][7:0]   <= cur_wdata[7:0];
    if (mem_we && byte_en[1]) mem[cur_idx][15:8]  <= cur_wdata[15:8];
    if (mem_we && byte_en[2]) mem[cur_idx][23:16] <= cur_wdata[23:16];
    if (mem_we && byte_en[3]) mem[cur_idx][31:24] <= cur_wdata[31:24];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rd_ok_d     = rd_ok_q;
`ifdef DMEM_RSP_BYTE_STROBE_EN
    wstrb_d     = wstrb_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          we_d        = req_we;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
`ifdef DMEM_RSP_BYTE_STROBE_EN
          wstrb_d     = req_wstrb;
`endif
          req_ready_d = 1'b0;
          if (LAT1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rd_ok_d     = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
    if (enter_resp) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = cur_err;
      rd_ok_d     = ~cur_we & ~cur_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_ok_q     <= 1'b0;
`ifdef DMEM_RSP_BYTE_STROBE_EN
      wstrb_q     <= 4'd0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rd_ok_q     <= rd_ok_d;
`ifdef DMEM_RSP_BYTE_STROBE_EN
      wstrb_q     <= wstrb_d;
`endif
    end
  end

  // Read data is only exposed for an error-free read that is being presented.
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rd_ok_q ? mem_rd_q : 32'd0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder: a LATENCY=2 instance checked per transaction
// against a word-array model, and a LATENCY=1 instance streamed for throughput.
module tb_data_mem_responder;

  localparam int LAT_A = 2;
  localparam int LAT_B = 1;
  localparam int AW    = 10;
`ifdef DMEM_RSP_BYTE_STROBE_EN
  localparam bit STROBE_EN = 1'b1;
`else
  localparam bit STROBE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic [3:0]  a_req_wstrb;
  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [3:0]  b_req_wstrb;

  data_mem_responder #(.ADDR_W(AW), .LATENCY(LAT_A)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_wstrb(a_req_wstrb),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  data_mem_responder #(.ADDR_W(AW), .LATENCY(LAT_B)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  int          test_cnt = 0;
  int          fail_cnt = 0;
  logic [31:0] model_mem [2][1024];
  logic [31:0] obs_rdata;
  logic        obs_err;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    test_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference behaviour: plain byte-address arithmetic on a word array.
  task automatic model_access(input int which, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] wstrb,
                              output logic [31:0] rdata, output logic err);
    int          idx;
    logic [3:0]  eff_strb;
    logic [31:0] m;
    err      = ((addr % 4) != 0) || (addr >= 32'(4 * 1024));
    idx      = int'((addr / 4) % 1024);
    eff_strb = STROBE_EN ? wstrb : 4'hF;
    rdata    = 32'd0;
    if (!err && !we) rdata = model_mem[which][idx];
    if (!err && we) begin
      for (int i = 0; i < 4; i++) begin
        if (eff_strb[i]) begin
          m = 32'hFF << (8 * i);
          model_mem[which][idx] = (model_mem[which][idx] & ~m) | (wdata & m);
        end
      end
    end
  endtask

  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input int hold);
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          edges;
    model_access(0, we, addr, wdata, wstrb, exp_rdata, exp_err);
    @(negedge clk);
    check_val("a_idle_ready", 32'(a_req_ready), 1);
    a_req_we    = we;
    a_req_addr  = addr;
    a_req_wdata = wdata;
    a_req_wstrb = wstrb;
    a_req_valid = 1'b1;
    a_rsp_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    // Garbage requests while busy must never be accepted.
    a_req_valid = 1'($urandom_range(0, 1));
    a_req_we    = 1'($urandom_range(0, 1));
    a_req_addr  = $urandom;
    a_req_wdata = $urandom;
    a_req_wstrb = 4'($urandom_range(0, 15));
    edges = 1;
    while (a_rsp_valid !== 1'b1 && edges < 20) begin
      a_rsp_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      edges++;
    end
    check_val("a_latency", 32'(edges), 32'(LAT_A));
    obs_rdata = a_rsp_rdata;
    obs_err   = a_rsp_err;
    check_val("a_rdata", a_rsp_rdata, exp_rdata);
    check_val("a_err", 32'(a_rsp_err), 32'(exp_err));
    check_val("a_busy_ready", 32'(a_req_ready), 0);
    a_rsp_ready = (hold == 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check_val("a_hold_valid", 32'(a_rsp_valid), 1);
      check_val("a_hold_rdata", a_rsp_rdata, exp_rdata);
      check_val("a_hold_err", 32'(a_rsp_err), 32'(exp_err));
      check_val("a_hold_ready", 32'(a_req_ready), 0);
    end
    a_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check_val("a_done_valid", 32'(a_rsp_valid), 0);
    check_val("a_done_ready", 32'(a_req_ready), 1);
    check_val("a_done_rdata", a_rsp_rdata, 0);
    check_val("a_done_err", 32'(a_rsp_err), 0);
    a_req_valid = 1'b0;
    a_rsp_ready = 1'($urandom_range(0, 1));
    $display("[TB] A %s addr=%08h wdata=%08h wstrb=%b hold=%0d -> rdata=%08h err=%0d edges=%0d",
             we ? "WR" : "RD", addr, wdata, wstrb, hold, obs_rdata, obs_err, edges);
  endtask

  // Accept a request on A, then assert rst mid-cycle 'edges_after' edges later.
  task automatic reset_mid(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int edges_after);
    @(negedge clk);
    a_req_we    = we;
    a_req_addr  = addr;
    a_req_wdata = wdata;
    a_req_wstrb = 4'hF;
    a_req_valid = 1'b1;
    a_rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    a_req_valid = 1'b0;
    repeat (edges_after) @(posedge clk);
    #2;
    check_val("rst_pre_valid", 32'(a_rsp_valid), 32'(edges_after >= LAT_A - 1));
    rst = 1'b1;
    #1;
    check_val("rst_async_ready", 32'(a_req_ready), 1);
    check_val("rst_async_valid", 32'(a_rsp_valid), 0);
    check_val("rst_async_rdata", a_rsp_rdata, 0);
    check_val("rst_async_err", 32'(a_rsp_err), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] A %s addr=%08h aborted by reset after %0d edges", we ? "WR" : "RD", addr, edges_after);
  endtask

  initial begin
    int          sel;
    logic [31:0] ad;
    int          accepts;
    int          resps;
    logic [31:0] exp_r;
    logic        exp_e;
    logic        bwe;
    logic [31:0] bad;
    logic [31:0] bwd;

    a_req_valid = 0; a_req_we = 0; a_req_addr = 0; a_req_wdata = 0; a_req_wstrb = 0; a_rsp_ready = 0;
    b_req_valid = 0; b_req_we = 0; b_req_addr = 0; b_req_wdata = 0; b_req_wstrb = 0; b_rsp_ready = 0;

    #1 rst = 1'b1;
    #2;
    check_val("reset_a_ready", 32'(a_req_ready), 1);
    check_val("reset_a_valid", 32'(a_rsp_valid), 0);
    check_val("reset_a_rdata", a_rsp_rdata, 0);
    check_val("reset_a_err", 32'(a_rsp_err), 0);
    check_val("reset_b_ready", 32'(b_req_ready), 1);
    check_val("reset_b_valid", 32'(b_rsp_valid), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle with rsp_ready toggling: outputs keep reset values.
    repeat (4) begin
      a_rsp_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
    end
    #1;
    check_val("idle_ready", 32'(a_req_ready), 1);
    check_val("idle_valid", 32'(a_rsp_valid), 0);
    check_val("idle_rdata", a_rsp_rdata, 0);
    check_val("idle_err", 32'(a_rsp_err), 0);

    do_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    check_val("wr10_err", 32'(obs_err), 0);
    check_val("wr10_rdata", obs_rdata, 0);
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, 0);
    check_val("rd10_rdata", obs_rdata, 32'hDEADBEEF);

    do_txn(1'b0, 32'h12, 32'h0, 4'h0, 0);
    check_val("rd12_err", 32'(obs_err), 1);
    check_val("rd12_rdata", obs_rdata, 0);
    do_txn(1'b0, 32'h1000, 32'h0, 4'h0, 0);
    check_val("rd1000_err", 32'(obs_err), 1);
    do_txn(1'b1, 32'h1010, 32'h12345678, 4'hF, 0);
    check_val("wr1010_err", 32'(obs_err), 1);
    do_txn(1'b1, 32'h11, 32'h87654321, 4'hF, 0);
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, 5);
    check_val("rd10_kept", obs_rdata, 32'hDEADBEEF);

    do_txn(1'b1, 32'h20, 32'h11223344, 4'hF, 0);
    do_txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0);
    do_txn(1'b0, 32'h20, 32'h0, 4'h0, 0);
    check_val("strobe_merge", obs_rdata, STROBE_EN ? 32'h11BB33DD : 32'hAABBCCDD);
    do_txn(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 1);
    do_txn(1'b0, 32'h20, 32'h0, 4'h0, 0);

    do_txn(1'b1, 32'h40, 32'h00000055, 4'hF, 0);
    reset_mid(1'b1, 32'h40, 32'hCAFEF00D, 0);
    do_txn(1'b0, 32'h40, 32'h0, 4'h0, 0);
    check_val("rst_wait_kept", obs_rdata, 32'h00000055);
    reset_mid(1'b0, 32'h40, 32'h0, 1);
    do_txn(1'b0, 32'h40, 32'h0, 4'h0, 0);
    check_val("rst_resp_kept", obs_rdata, 32'h00000055);

    for (int i = 0; i < 16; i++) do_txn(1'b1, 32'h100 + 32'(4 * i), $urandom, 4'hF, 0);
    for (int n = 0; n < 80; n++) begin
      sel = int'($urandom_range(0, 9));
      ad  = 32'h100 + ($urandom_range(0, 15) << 2);
      if (sel == 8) ad = ad | $urandom_range(1, 3);
      else if (sel == 9) ad = ad | ($urandom_range(1, 32'hFFFFF) << 12);
      do_txn(1'($urandom_range(0, 1)), ad, $urandom, 4'($urandom_range(0, 15)),
             int'($urandom_range(0, 3)));
    end

    // LATENCY=1 stream: request held valid, response always taken.
    accepts = 0;
    resps   = 0;
    exp_r   = 32'd0;
    exp_e   = 1'b0;
    b_rsp_ready = 1'b1;
    b_req_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check_val("b_ready_phase", 32'(b_req_ready), 32'(i % 2 == 0));
      if (b_rsp_valid === 1'b1) begin
        resps++;
        check_val("b_rdata", b_rsp_rdata, exp_r);
        check_val("b_err", 32'(b_rsp_err), 32'(exp_e));
        $display("[TB] B %s addr=%08h -> rdata=%08h err=%0d", b_req_we ? "WR" : "RD",
                 b_req_addr, b_rsp_rdata, b_rsp_err);
      end
      if (b_req_ready === 1'b1) begin
        if (accepts < 8) begin
          bwe = 1'b1; bad = 32'h200 + 32'(4 * accepts);
        end else if (accepts == 8) begin
          bwe = 1'b1; bad = 32'h200 | 32'h10000;
        end else if (accepts == 9) begin
          bwe = 1'b0; bad = 32'h202;
        end else begin
          bwe = 1'b0; bad = 32'h200 + 32'(4 * (accepts - 10));
        end
        bwd = $urandom;
        model_access(1, bwe, bad, bwd, 4'hF, exp_r, exp_e);
        b_req_we    = bwe;
        b_req_addr  = bad;
        b_req_wdata = bwd;
        b_req_wstrb = 4'hF;
        accepts++;
      end
    end
    b_req_valid = 1'b0;
    check_val("b_accepts", 32'(accepts), 16);
    check_val("b_responses", 32'(resps), 16);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter ADDR_W, default 10: log2 of the word depth; storage is 2**ADDR_W words of 32 bits.
REQ-002 Parameter LATENCY, default 2: edges from request acceptance to rsp_valid high; legal range 1..15.
REQ-003 Clocking is fixed: one clock, clk; reset rst is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 req_valid  in  1  initiator presents a request.
REQ-007 req_ready  out  1  responder accepts a request this cycle.
REQ-008 req_we  in  1  1 = write, 0 = read.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  write data.
REQ-011 req_wstrb  in  4  byte-lane write enables; bit i covers bits [8i+7:8i].
REQ-012 rsp_valid  out  1  response is presented.
REQ-013 rsp_ready  in  1  initiator takes the response.
REQ-014 rsp_rdata  out  32  read data; 0 for writes and errors.
REQ-015 rsp_err  out  1  request was misaligned or out of range.

Function
REQ-016 The FSM SHALL have three states: IDLE, WAIT and RESP; req_ready = 1 only in IDLE.
REQ-017 A request SHALL be accepted at a rising edge where req_valid=1 and req_ready=1; req_we, req_addr, req_wdata and req_wstrb are latched at that edge.
REQ-018 On acceptance, the FSM SHALL go to RESP if LATENCY=1, otherwise to WAIT with the counter loaded with LATENCY-2.
REQ-019 In WAIT, the counter SHALL decrement each edge; the edge where the counter equals 0 moves the FSM to RESP.
REQ-020 rsp_valid SHALL rise exactly LATENCY edges after the acceptance edge.
REQ-021 The storage write and the read sample SHALL both occur on the edge entering RESP; rsp_rdata holds the word stored before that write.
REQ-022 Word index = latched addr[ADDR_W+1:2].
REQ-023 Error condition: addr[1:0] != 0, or any of addr[31:ADDR_W+2] = 1; an error SHALL suppress the write, force rsp_err=1 and force rsp_rdata=0.
REQ-024 A write SHALL return rsp_rdata=0 and rsp_err=0 when error-free.
REQ-025 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until an edge with rsp_ready=1; that edge returns the FSM to IDLE.
REQ-026 Back-to-back throughput SHALL be one transaction per LATENCY+1 cycles minimum; req_valid with no acceptance creates no state change.
REQ-027 rsp_ready outside RESP SHALL be ignored.
REQ-028 An X-free req_valid=0 in IDLE SHALL leave all outputs at their reset values.

Reset
REQ-029 Asserting rst SHALL immediately force: state IDLE, counter 0, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0.
REQ-030 Reset asserted during WAIT or RESP SHALL abort the transaction; a pending write that has not reached the edge entering RESP SHALL NOT be performed.
REQ-031 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-032 With DMEM_RSP_BYTE_STROBE_EN defined, writes SHALL update only the byte lanes whose req_wstrb bit is 1; writes with wstrb=0000 change nothing but still respond.
REQ-033 Without DMEM_RSP_BYTE_STROBE_EN, req_wstrb SHALL be ignored and every error-free write SHALL update the full 32-bit word.

Verification
REQ-034 LATENCY=2: write addr 0x10, data 0xDEADBEEF, then read 0x10 -> rsp_valid 2 edges after each acceptance; read returns 0xDEADBEEF with rsp_err=0.
REQ-035 Read addr 0x12 (misaligned) and 0x1000 (out of range with ADDR_W=10) -> rsp_err=1 and rdata=0; a prior write to 0x10 is unchanged.
REQ-036 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stay stable and req_ready stays 0; the edge with rsp_ready=1 returns to IDLE.
REQ-037 With the macro defined: word 0x20 = 0x11223344, then write 0xAABBCCDD with wstrb=0101 -> read returns 0x11BB33DD; without the macro -> 0xAABBCCDD.
REQ-038 Write 0x55 to 0x40, assert rst in WAIT, then read 0x40 -> old contents returned; all outputs reach reset values while rst is high without waiting for a clock edge.
REQ-039 LATENCY=1 with continuous req_valid and rsp_ready=1 -> exactly one acceptance every 2 cycles.
